// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit FND scan controller.
package fnd_pkg;

    localparam int         NDIG        = 4;
    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [3:0] COM_OFF     = 4'b1111;
    localparam int         FONT_DP_BIT = 0;

    typedef logic [1:0] dig_idx_t;

endpackage

// File: rtl/decoder_7seg.sv
// Hex nibble to 7-segment font, active-high {a,b,c,d,e,f,g,dp}; dp is always 0 here.
module decoder_7seg (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit multiplexed FND scanner with guard blanking and frame-synchronous double buffer.
// Optional build macro FND_LZ_BLANK_EN enables leading-zero blanking of digits 3..1.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        enable,
    output logic [7:0]  seg_7,
    output logic [3:0]  com,
    output logic        frame_tick
);

    localparam int                CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  DIV_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam dig_idx_t          LAST_DIG  = dig_idx_t'(NDIG - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    dig_idx_t         dig_q, dig_d;
    logic [15:0]      disp_val_q, disp_val_d, pend_val_q, pend_val_d;
    logic [3:0]       disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       com_q, com_d;
    logic             frame_tick_q, frame_tick_d;

    logic             last_slot, boundary, lz_blank;
    logic [3:0]       cur_nib;
    logic [7:0]       font_seg, glyph, dp_vec;

    decoder_7seg u_font (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    assign last_slot = (div_cnt_q == DIV_MAX);
    assign boundary  = last_slot && (dig_q == LAST_DIG);
    assign cur_nib   = disp_val_q[{dig_q, 2'b00} +: 4];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_cnt_d    = last_slot ? '0 : div_cnt_q + 1'b1;
        dig_d        = last_slot ? dig_q + 1'b1 : dig_q;
        frame_tick_d = boundary;

        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;

        // Transfer reads the old pending contents; a coincident load re-arms for the next frame.
        if (boundary && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        lz_blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        unique case (dig_q)
            2'd3:    lz_blank = (disp_val_q[15:12] == 4'h0);
            2'd2:    lz_blank = (disp_val_q[15:8]  == 8'h00);
            2'd1:    lz_blank = (disp_val_q[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    always_comb begin
        dp_vec              = '0;
        dp_vec[FONT_DP_BIT] = disp_dp_q[dig_q];
        glyph               = lz_blank ? 8'h00 : font_seg;
        com_d               = COM_OFF;
        seg_d               = SEG_OFF;
        if (enable && (div_cnt_q >= BLANK_LIM)) begin
            com_d = ~(4'b0001 << dig_q);
            seg_d = ~(glyph | dp_vec);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            dig_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            com_q        <= COM_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_q        <= dig_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            com_q        <= com_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_7      = seg_q;
    assign com        = com_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized bench for fnd_scan_ctrl against a cycle-count reference model (REFRESH_DIV=8, BLANK_CYC=2).
module tb_fnd_scan_ctrl;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * RDIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic [7:0]  seg_7;
    logic [3:0]  com;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference state: s counts edges since reset release; display contents as the spec describes them.
    int          s;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pv;

    fnd_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .enable     (enable),
        .seg_7      (seg_7),
        .com        (com),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Active-low glyphs as seen on the pins, dp bit off.
    function automatic logic [7:0] glyph_n(input logic [3:0] n);
        case (n)
            4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
            4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
            4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
            4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
        endcase
    endfunction

    task automatic model_reset();
        s = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pv = 1'b0;
    endtask

    // Apply inputs for one clock, then compare outputs produced from the pre-edge model state.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic en);
        int          pos, dg;
        logic        blank;
        logic [7:0]  exp_seg;
        logic [3:0]  exp_com;
        load = ld; value = v; dp_in = d; enable = en;
        @(posedge clk);
        #1;
        pos = s % RDIV;
        dg  = (s / RDIV) % 4;
        exp_com = 4'b1111;
        exp_seg = 8'hFF;
        if (en && pos >= BLANK) begin
            exp_com = 4'b1111 ^ (4'b0001 << dg);
`ifdef FND_LZ_BLANK_EN
            blank = (dg != 0) && ((m_disp >> (4 * dg)) == 16'h0);
`else
            blank = 1'b0;
`endif
            exp_seg = blank ? 8'hFF : glyph_n(4'((m_disp >> (4 * dg)) & 16'hF));
            if (m_dp[dg]) exp_seg[0] = 1'b0;
        end
        check("com", 16'(com), 16'(exp_com));
        check("seg_7", 16'(seg_7), 16'(exp_seg));
        check("frame_tick", 16'(frame_tick), 16'((s % FRAME) == FRAME - 1));
        if ((s % FRAME) == FRAME - 1 && m_pv) begin
            m_disp = m_pend; m_dp = m_pdp; m_pv = 1'b0;
        end
        if (ld) begin
            m_pend = v; m_pdp = d; m_pv = 1'b1;
        end
        s++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b1);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (s % FRAME) != phase; i++) idle(1);
    endtask

    initial begin
        logic en_r;
        reset_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; enable = 1'b1;
        model_reset();
        #12;
        check("rst_com", 16'(com), 16'h000F);
        check("rst_seg", 16'(seg_7), 16'h00FF);
        check("rst_tick", 16'(frame_tick), 16'h0);
        #10 reset_n = 1'b1;

        // Scan order and frame_tick period with an all-zero display.
        idle(2 * FRAME);

        // Mid-frame load of 1234, visible from the next digit0 slot.
        run_to(10);
        step(1'b1, 16'h1234, 4'h0, 1'b1);
        run_to(2);
        idle(1);
        check("upd_dig0_seg", 16'(seg_7), 16'h0099);
        check("upd_dig0_com", 16'(com), 16'h000E);
        run_to(26);
        idle(1);
        check("upd_dig3_seg", 16'(seg_7), 16'h009F);

        // Coincident load at the boundary with a pending value, then with none pending.
        run_to(5);
        step(1'b1, 16'h1111, 4'h0, 1'b1);
        run_to(FRAME - 1);
        step(1'b1, 16'h5678, 4'h0, 1'b1);
        idle(2 * FRAME);
        run_to(FRAME - 1);
        step(1'b1, 16'hABCD, 4'h3, 1'b1);
        idle(2 * FRAME);

        // Decimal point on digit2 with a zero value.
        run_to(3);
        step(1'b1, 16'h0000, 4'b0100, 1'b1);
        idle(2 * FRAME);

        // Async reset mid digit2 slot: dark without a clock edge, then restart at digit0.
        run_to(20);
        idle(1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_com", 16'(com), 16'h000F);
        check("async_rst_seg", 16'(seg_7), 16'h00FF);
        @(posedge clk);
        #1;
        check("hold_rst_com", 16'(com), 16'h000F);
        #3 reset_n = 1'b1;
        model_reset();
        idle(FRAME);

        // A full dark frame: timer and frame_tick keep running.
        for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
        idle(FRAME);

        // Leading-zero candidates.
        step(1'b1, 16'h0042, 4'h0, 1'b1);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 4'h0, 1'b1);
        idle(2 * FRAME);

        // Randomized loads and enable stretches.
        en_r = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(39) == 0) en_r = ~en_r;
            step($urandom_range(9) == 0,
                 ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom),
                 4'($urandom), en_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
4-digit multiplexed FND (7-segment) scan controller. It consumes four hex/BCD nibbles, e.g. the bin_to_dec output, and drives the board's shared seg_7/com lines.
- Time-slices one digit at a time, with a ghost-guard blank between digits.
- Double-buffers the input value so an update never tears mid-frame.
- Sits directly downstream of the binary-to-BCD stage and wraps the decoder_7seg font table.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYC, 1000, cycles at the start of each slot with all digits off; must be < REFRESH_DIV; 0 disables the guard.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
value  in  16  display nibbles; [3:0] is digit0 (rightmost), [15:12] is digit3.
dp_in  in  4  decimal point per digit; bit i maps to digit i, active-high.
load  in  1  one-cycle strobe; captures value/dp_in into the pending buffer.
enable  in  1  1 = display on; 0 = all digits dark.
seg_7  out  8  segments {a,b,c,d,e,f,g,dp}, MSB = a, active-low.
com  out  4  digit enables, active-low, one-hot-zero; com[i] selects digit i.
frame_tick  out  1  one-cycle pulse at the end of each digit3 slot.

Behaviour:
- Reset (async, reset_n = 0):
  - div_cnt = 0, dig = 0.
  - disp_val = 0, disp_dp = 0.
  - pend_val = 0, pend_dp = 0, pend_valid = 0.
  - com = 4'b1111, seg_7 = 8'hFF, frame_tick = 0.
  - Release is synchronous to the next rising edge of clk.
- Slot timer:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, dig increments mod 4 (3 -> 0).
  - Frame = 4*REFRESH_DIV cycles.
- boundary = (div_cnt == REFRESH_DIV-1) && (dig == 3).
  - frame_tick is registered: it is 1 for the single cycle after the boundary edge.
- Pending buffer:
  - load = 1 writes pend_val/pend_dp and sets pend_valid.
  - Repeated loads before a boundary overwrite; last one wins.
- Transfer: on the boundary edge with pend_valid = 1, copy pend to disp and clear pend_valid.
  - The new value therefore first appears in the digit0 slot of the next frame.
- load coincident with boundary:
  - The transfer uses the old pend contents.
  - pend takes the new value, and pend_valid ends at 1, so the new value applies at the following boundary.
  - If pend_valid was 0, the transfer is skipped and the new load waits one frame.
- Output stage (registered, 1-cycle latency from div_cnt/dig state):
  - Guard interval (div_cnt < BLANK_CYC) or enable = 0: com = 4'b1111, seg_7 = 8'hFF.
  - Otherwise: com = ~(4'b0001 << dig), seg_7 = ~(font(disp_val nibble[dig]) | {7'b0, disp_dp[dig]}).
- enable does not stop the timer. Loads, transfers and frame_tick continue while enable = 0.
- Changing value/dp_in without load has no effect on the display.
- Reset mid-slot forces dark outputs immediately. After release, scanning restarts at digit0, beginning with a guard interval.

Optional Feature:
FND_LZ_BLANK_EN: leading-zero blanking.
- Defined: digit i (i = 3..1) is blanked (segments a..g off) when nibble i and every higher nibble are 0.
  - The dp bit of a blanked digit is still honoured.
  - com still asserts normally.
  - digit0 is never blanked.
- Undefined: all four digits are always shown.

Decomposition:
- Package fnd_pkg:
  - NDIG = 4, SEG_OFF = 8'hFF, COM_OFF = 4'b1111.
  - typedef dig_idx_t (2-bit).
  - FONT_DP_BIT = 0.
- Sub-module: one instance of the existing decoder_7seg (active-high font). Inversion and dp OR are done in fnd_scan_ctrl.

Test Plan:
All scenarios run with REFRESH_DIV = 8, BLANK_CYC = 2.
1. Scan order: after reset release, com repeats [1111 x2, 1110 x6], [1111 x2, 1101 x6], [1111 x2, 1011 x6], [1111 x2, 0111 x6]; frame_tick is a 1-cycle pulse every 32 cycles.
2. Update timing: load value = 16'h1234 mid-frame -> display unchanged until frame_tick; next digit0 slot gives seg_7 = 8'b1001_1001 ("4") and com = 1110; digit3 shows "1" as 8'b1001_1111.
3. Coincident load: pend = 16'h1111 pending, then load 16'h5678 on the boundary cycle -> next frame shows 1111, the frame after shows 5678.
4. Decimal point: value = 0, dp_in = 4'b0100, load -> digit2 seg_7 = 8'b0000_0010; other digits show 8'b0000_0011.
5. Reset and enable:
   - reset_n low during the digit2 slot -> com = 1111 and seg_7 = FF without a clk edge.
   - enable = 0 for a whole frame -> com stays 1111 while frame_tick still pulses at 32 cycles.
6. FND_LZ_BLANK_EN defined, value = 16'h0042 -> digits 3 and 2 give seg_7 = FF, digit1 shows "4", digit0 shows "2"; with value = 0, digit0 shows "0".
